commit_ctrl: RTL and testbench
==============================

# commit_ctrl

Reorder-buffer head commit sequencer. Inspects the ROB head each cycle and retires it in program order. Register-writing instructions go to the architectural register file's commit port. Stores are handed to the load/store buffer with a request/done handshake. Branch mispredictions trigger a timed `roll_back` pulse that flushes the register file, ROB and reservation stations.

## Interface
Parameters:
- `ENTRY_WIDTH`, default 4: width of a ROB entry tag.
- `FLUSH_CYCLES`, default 2: number of cycles `roll_back` stays high per misprediction; legal range 1..15.

Ports:
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst_in`  in  1: reset, asynchronous, active-low.
- `rdy_in`  in  1: global ready; low freezes the block.
- `head_valid`  in  1: ROB non-empty.
- `head_ready`  in  1: head result available.
- `head_type`  in  2: head instruction class. 00 = REG, 01 = STORE, 10 = BRANCH, 11 = reserved (treated as REG).
- `head_entry`  in  ENTRY_WIDTH: head ROB tag.
- `head_des`  in  6: destination register; 0 = none.
- `head_result`  in  32: value to write.
- `head_mispredict`  in  1: branch resolved wrong; meaningful only for BRANCH.
- `head_target`  in  32: correct PC after a misprediction.
- `head_pop`  out  1: combinational; ROB advances its head on the edge where this is high.
- `rob_commit`  out  1: registered one-cycle pulse to the register file.
- `rob_entry`  out  ENTRY_WIDTH: registered; tag that accompanies `rob_commit`.
- `rob_des`  out  6: registered; destination that accompanies `rob_commit`.
- `rob_result`  out  32: registered; value that accompanies `rob_commit`.
- `store_req`  out  1: registered level; held until `store_done`.
- `store_entry`  out  ENTRY_WIDTH: registered; ROB tag of the store.
- `store_done`  in  1: one-cycle acknowledgement from the load/store buffer.
- `roll_back`  out  1: registered; flush to the whole core.
- `new_pc`  out  32: registered; fetch redirect target, valid while `roll_back` is high.
- `commit_cnt`  out  32: registered count of retired instructions; wraps modulo 2^32.

## Operation
- States: RUN, STORE_WAIT, FLUSH.
- Reset value of every output is 0. Reset state is RUN and the flush counter is 0. Reset asserted mid-store or mid-flush aborts immediately.
- The head is retirable when `head_valid && head_ready && rdy_in`.
- **RUN, REG or reserved type:**
  - `head_pop` = 1.
  - If `head_des` != 0, next cycle `rob_commit` = 1 with `rob_entry`/`rob_des`/`rob_result` = `head_entry`/`head_des`/`head_result`.
  - If `head_des` == 0, the instruction retires with no commit pulse.
- **RUN, STORE:**
  - `head_pop` = 0.
  - Register `store_req` = 1 and `store_entry` = `head_entry`, then go to STORE_WAIT.
- **STORE_WAIT:**
  - When `store_done && rdy_in`: `head_pop` = 1, `store_req` clears next cycle, state returns to RUN.
  - `store_done` received while `rdy_in` is low is ignored; the load/store buffer must re-assert it.
- **RUN, BRANCH with `head_mispredict` = 0:** handled exactly as REG (covers jal/jalr link writes).
- **RUN, BRANCH with `head_mispredict` = 1:**
  - `head_pop` = 1, with a link-register commit if `head_des` != 0.
  - Next cycle `roll_back` = 1 and `new_pc` = `head_target`. Enter FLUSH with counter = `FLUSH_CYCLES`-1.
- **FLUSH:**
  - `head_pop` = 0 and head inputs are ignored.
  - The counter decrements each ready cycle. `roll_back` deasserts on the edge after the counter reaches 0, and the state returns to RUN.
  - `new_pc` holds its value until the next misprediction.
- `commit_cnt` increments by 1 on every edge where `head_pop` = 1.
- **`rdy_in` low:**
  - `head_pop` = 0 and `rob_commit` deasserts.
  - State, flush counter, `commit_cnt`, `store_req`, `roll_back` and `new_pc` all hold.
- A head that is not ready, or an empty ROB, produces no pop and no pulses. The state machine stays in its current state.

## Timing
- Retire throughput: 1 instruction per cycle for REG and BRANCH heads.
- Register-file write latency: `rob_commit` is high in the cycle after the pop edge.
- Store retire: request edge, plus N wait cycles, plus the pop edge. Minimum 2 cycles per store.
- Misprediction: `roll_back` is high for exactly `FLUSH_CYCLES` ready cycles, starting the cycle after the pop edge. The first retire after the flush can happen in the cycle after `roll_back` falls.
- Simultaneous link commit and rollback: `rob_commit` and `roll_back` both rise in the same cycle. The register file applies rollback priority; this is intentional.

## Test plan
- Reset: hold `rst_in` = 0 for 3 cycles with a valid head present -> all outputs 0 and no pop. Release -> REG head (`head_des` = 5, `head_result` = 0xDEADBEEF, `head_entry` = 3) pops immediately; the next cycle shows `rob_commit` = 1, `rob_des` = 5, `rob_entry` = 3; `commit_cnt` = 1.
- Back-to-back: 4 ready REG heads, one of them with `head_des` = 0 -> 4 consecutive pops, 3 `rob_commit` pulses, `commit_cnt` = 4.
- Store: STORE head with `head_entry` = 7 and `store_done` after 3 cycles -> `store_req` = 1 with `store_entry` = 7 for 4 cycles, one pop in the `store_done` cycle, `store_req` low the next cycle.
- Mispredict: BRANCH head, `head_mispredict` = 1, `head_target` = 0x1000, `head_des` = 1, `FLUSH_CYCLES` = 2 -> pop; next cycle `rob_commit` = 1 and `roll_back` = 1 with `new_pc` = 0x1000; `roll_back` stays high 2 cycles; no pop during FLUSH even with a valid ready head.
- Stall: drop `rdy_in` for 2 cycles mid-FLUSH and mid-STORE_WAIT -> no pops; `roll_back` and `store_req` held; the flush counter does not advance; `store_done` pulsed during the stall is ignored.
- Wrap: preload `commit_cnt` to 0xFFFFFFFF through a long run (or a bench force), retire 1 instruction -> `commit_cnt` = 0.

Source files
------------

// File: rtl/commit_ctrl.sv
// ROB head commit sequencer: retires the head in program order, hands stores to the
// load/store buffer and raises a timed roll_back flush on branch mispredictions.
module commit_ctrl #(
  parameter int unsigned ENTRY_WIDTH  = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   head_valid,
  input  logic                   head_ready,
  input  logic [1:0]             head_type,
  input  logic [ENTRY_WIDTH-1:0] head_entry,
  input  logic [5:0]             head_des,
  input  logic [31:0]            head_result,
  input  logic                   head_mispredict,
  input  logic [31:0]            head_target,
  output logic                   head_pop,
  output logic                   rob_commit,
  output logic [ENTRY_WIDTH-1:0] rob_entry,
  output logic [5:0]             rob_des,
  output logic [31:0]            rob_result,
  output logic                   store_req,
  output logic [ENTRY_WIDTH-1:0] store_entry,
  input  logic                   store_done,
  output logic                   roll_back,
  output logic [31:0]            new_pc,
  output logic [31:0]            commit_cnt
);

  typedef enum logic [1:0] {StRun, StStoreWait, StFlush} state_e;

  localparam logic [1:0] TypeStore  = 2'b01;
  localparam logic [1:0] TypeBranch = 2'b10;
  localparam logic [3:0] FlushInit  = 4'(FLUSH_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             flush_cnt_q, flush_cnt_d;
  logic                   rob_commit_q, rob_commit_d;
  logic [ENTRY_WIDTH-1:0] rob_entry_q, rob_entry_d;
  logic [5:0]             rob_des_q, rob_des_d;
  logic [31:0]            rob_result_q, rob_result_d;
  logic                   store_req_q, store_req_d;
  logic [ENTRY_WIDTH-1:0] store_entry_q, store_entry_d;
  logic                   roll_back_q, roll_back_d;
  logic [31:0]            new_pc_q, new_pc_d;
  logic [31:0]            commit_cnt_q, commit_cnt_d;
  logic                   pop;
  logic                   retire;

  assign retire = head_valid && head_ready && rdy_in;

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    rob_commit_d  = 1'b0;
    rob_entry_d   = rob_entry_q;
    rob_des_d     = rob_des_q;
    rob_result_d  = rob_result_q;
    store_req_d   = store_req_q;
    store_entry_d = store_entry_q;
    roll_back_d   = roll_back_q;
    new_pc_d      = new_pc_q;
    pop           = 1'b0;

    unique case (state_q)
      StRun: begin
        if (retire) begin
          if (head_type == TypeStore) begin
            store_req_d   = 1'b1;
            store_entry_d = head_entry;
            state_d       = StStoreWait;
          end else begin
            // REG, reserved and BRANCH all retire here; a mispredict adds the flush.
            pop = 1'b1;
            if (head_des != 6'd0) begin
              rob_commit_d = 1'b1;
              rob_entry_d  = head_entry;
              rob_des_d    = head_des;
              rob_result_d = head_result;
            end
            if (head_type == TypeBranch && head_mispredict) begin
              roll_back_d = 1'b1;
              new_pc_d    = head_target;
              flush_cnt_d = FlushInit;
              state_d     = StFlush;
            end
          end
        end
      end
      StStoreWait: begin
        if (store_done && rdy_in) begin
          pop         = 1'b1;
          store_req_d = 1'b0;
          state_d     = StRun;
        end
      end
      StFlush: begin
        if (rdy_in) begin
          if (flush_cnt_q == 4'd0) begin
            roll_back_d = 1'b0;
            state_d     = StRun;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
      end
      default: state_d = StRun;
    endcase

    commit_cnt_d = commit_cnt_q + 32'(pop);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= StRun;
      flush_cnt_q   <= 4'd0;
      rob_commit_q  <= 1'b0;
      rob_entry_q   <= '0;
      rob_des_q     <= 6'd0;
      rob_result_q  <= 32'd0;
      store_req_q   <= 1'b0;
      store_entry_q <= '0;
      roll_back_q   <= 1'b0;
      new_pc_q      <= 32'd0;
      commit_cnt_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      rob_commit_q  <= rob_commit_d;
      rob_entry_q   <= rob_entry_d;
      rob_des_q     <= rob_des_d;
      rob_result_q  <= rob_result_d;
      store_req_q   <= store_req_d;
      store_entry_q <= store_entry_d;
      roll_back_q   <= roll_back_d;
      new_pc_q      <= new_pc_d;
      commit_cnt_q  <= commit_cnt_d;
    end
  end

  // Pop is combinational; gate it so nothing advances the ROB while reset is held.
  assign head_pop    = pop && rst_in;
  assign rob_commit  = rob_commit_q;
  assign rob_entry   = rob_entry_q;
  assign rob_des     = rob_des_q;
  assign rob_result  = rob_result_q;
  assign store_req   = store_req_q;
  assign store_entry = store_entry_q;
  assign roll_back   = roll_back_q;
  assign new_pc      = new_pc_q;
  assign commit_cnt  = commit_cnt_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: inputs change on the falling edge, registered outputs
// are checked on the falling edge after the rising edge that produced them.
module tb_commit_ctrl;

  localparam logic [1:0] TReg    = 2'b00;
  localparam logic [1:0] TStore  = 2'b01;
  localparam logic [1:0] TBranch = 2'b10;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        head_valid;
  logic        head_ready;
  logic [1:0]  head_type;
  logic [3:0]  head_entry;
  logic [5:0]  head_des;
  logic [31:0] head_result;
  logic        head_mispredict;
  logic [31:0] head_target;
  logic        head_pop;
  logic        rob_commit;
  logic [3:0]  rob_entry;
  logic [5:0]  rob_des;
  logic [31:0] rob_result;
  logic        store_req;
  logic [3:0]  store_entry;
  logic        store_done;
  logic        roll_back;
  logic [31:0] new_pc;
  logic [31:0] commit_cnt;

  int checks;
  int errors;
  logic [31:0] exp_cnt;

  commit_ctrl #(
    .ENTRY_WIDTH (4),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .head_valid     (head_valid),
    .head_ready     (head_ready),
    .head_type      (head_type),
    .head_entry     (head_entry),
    .head_des       (head_des),
    .head_result    (head_result),
    .head_mispredict(head_mispredict),
    .head_target    (head_target),
    .head_pop       (head_pop),
    .rob_commit     (rob_commit),
    .rob_entry      (rob_entry),
    .rob_des        (rob_des),
    .rob_result     (rob_result),
    .store_req      (store_req),
    .store_entry    (store_entry),
    .store_done     (store_done),
    .roll_back      (roll_back),
    .new_pc         (new_pc),
    .commit_cnt     (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_head(input logic v, input logic r, input logic [1:0] t,
                          input logic [3:0] e, input logic [5:0] d, input logic [31:0] res,
                          input logic mp, input logic [31:0] tgt);
    head_valid      = v;
    head_ready      = r;
    head_type       = t;
    head_entry      = e;
    head_des        = d;
    head_result     = res;
    head_mispredict = mp;
    head_target     = tgt;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    store_done = 1'b0;
    set_head(1'b1, 1'b1, TReg, 4'd3, 6'd5, 32'hDEADBEEF, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    checks++;
    if ({head_pop, rob_commit, store_req, roll_back} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {head_pop, rob_commit, store_req, roll_back});
    end
    checks++;
    if ({rob_entry, rob_des, rob_result, store_entry, new_pc, commit_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_data: entry %0h des %0h result %0h sentry %0h pc %0h cnt %0h expected all 0",
               rob_entry, rob_des, rob_result, store_entry, new_pc, commit_cnt);
    end
    rst_in = 1'b1;
    #1;
    checks++;
    if (head_pop !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_pop: got %b expected 1", head_pop);
    end
    exp_cnt = 32'd1;
    @(negedge clk);
    checks++;
    if ({rob_commit, rob_des, rob_entry, rob_result} !== {1'b1, 6'd5, 4'd3, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL reset_first_commit: got commit %b des %0d entry %0d result %h expected 1 5 3 deadbeef",
               rob_commit, rob_des, rob_entry, rob_result);
    end
    checks++;
    if (commit_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected %0d", commit_cnt, exp_cnt);
    end
    head_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [5:0] des_tab [4];
    int pulses;
    pulses = 0;
    des_tab[0] = 6'd2;
    des_tab[1] = 6'd0;
    des_tab[2] = 6'd4;
    des_tab[3] = 6'd6;
    @(negedge clk);
    checks++;
    if (rob_commit !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_commit: got %b expected 0", rob_commit);
    end
    for (int i = 0; i < 4; i++) begin
      set_head(1'b1, 1'b1, TReg, 4'(i + 1), des_tab[i], 32'h100 + 32'(i), 1'b0, 32'd0);
      #1;
      checks++;
      if (head_pop !== 1'b1) begin
        errors++;
        $display("FAIL b2b_pop[%0d]: got %b expected 1", i, head_pop);
      end
      exp_cnt++;
      @(negedge clk);
      checks++;
      if (rob_commit !== (des_tab[i] != 6'd0)) begin
        errors++;
        $display("FAIL b2b_commit[%0d]: got %b expected %b", i, rob_commit, des_tab[i] != 6'd0);
      end
      if (rob_commit === 1'b1) pulses++;
    end
    checks++;
    if ({rob_des, rob_entry, rob_result} !== {6'd6, 4'd4, 32'h103}) begin
      errors++;
      $display("FAIL b2b_last: got des %0d entry %0d result %h expected 6 4 103",
               rob_des, rob_entry, rob_result);
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d expected 3", pulses);
    end
    checks++;
    if (commit_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_cnt: got %0d expected %0d", commit_cnt, exp_cnt);
    end
    head_valid = 1'b0;
  endtask

  task automatic test_store;
    set_head(1'b1, 1'b1, TStore, 4'd7, 6'd9, 32'h55, 1'b0, 32'd0);
    #1;
    checks++;
    if (head_pop !== 1'b0) begin
      errors++;
      $display("FAIL store_req_pop: got %b expected 0", head_pop);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({store_req, store_entry, rob_commit} !== {1'b1, 4'd7, 1'b0}) begin
        errors++;
        $display("FAIL store_wait[%0d]: got req %b entry %0d commit %b expected 1 7 0",
                 k, store_req, store_entry, rob_commit);
      end
      store_done = (k == 4);
      #1;
      checks++;
      if (head_pop !== (k == 4)) begin
        errors++;
        $display("FAIL store_pop[%0d]: got %b expected %b", k, head_pop, k == 4);
      end
    end
    exp_cnt++;
    @(negedge clk);
    store_done = 1'b0;
    head_valid = 1'b0;
    checks++;
    if ({store_req, commit_cnt} !== {1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL store_done: got req %b cnt %0d expected 0 %0d", store_req, commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_mispredict;
    @(negedge clk);
    set_head(1'b1, 1'b1, TBranch, 4'd9, 6'd1, 32'h44, 1'b1, 32'h1000);
    #1;
    checks++;
    if (head_pop !== 1'b1) begin
      errors++;
      $display("FAIL mp_pop: got %b expected 1", head_pop);
    end
    exp_cnt++;
    @(negedge clk);
    checks++;
    if ({rob_commit, rob_des, rob_entry, roll_back, new_pc} !== {1'b1, 6'd1, 4'd9, 1'b1, 32'h1000}) begin
      errors++;
      $display("FAIL mp_first: got commit %b des %0d entry %0d rb %b pc %h expected 1 1 9 1 1000",
               rob_commit, rob_des, rob_entry, roll_back, new_pc);
    end
    set_head(1'b1, 1'b1, TReg, 4'd10, 6'd3, 32'h77, 1'b0, 32'd0);
    #1;
    checks++;
    if (head_pop !== 1'b0) begin
      errors++;
      $display("FAIL mp_flush_pop1: got %b expected 0", head_pop);
    end
    @(negedge clk);
    checks++;
    if ({roll_back, rob_commit, head_pop} !== 3'b100) begin
      errors++;
      $display("FAIL mp_second: got rb %b commit %b pop %b expected 1 0 0",
               roll_back, rob_commit, head_pop);
    end
    @(negedge clk);
    checks++;
    if ({roll_back, head_pop, new_pc} !== {1'b0, 1'b1, 32'h1000}) begin
      errors++;
      $display("FAIL mp_end: got rb %b pop %b pc %h expected 0 1 1000", roll_back, head_pop, new_pc);
    end
    exp_cnt++;
    @(negedge clk);
    head_valid = 1'b0;
    checks++;
    if ({rob_commit, rob_des, commit_cnt} !== {1'b1, 6'd3, exp_cnt}) begin
      errors++;
      $display("FAIL mp_after: got commit %b des %0d cnt %0d expected 1 3 %0d",
               rob_commit, rob_des, commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall;
    set_head(1'b1, 1'b1, TBranch, 4'd2, 6'd0, 32'h0, 1'b1, 32'h2000);
    exp_cnt++;
    @(negedge clk);
    rdy_in = 1'b0;
    set_head(1'b1, 1'b1, TReg, 4'd4, 6'd0, 32'h0, 1'b0, 32'd0);
    // Cycles 1-2 stalled, 3-4 ready: roll_back must be high in all four.
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) rdy_in = 1'b1;
      #1;
      checks++;
      if ({roll_back, head_pop, new_pc} !== {1'b1, 1'b0, 32'h2000}) begin
        errors++;
        $display("FAIL stall_flush[%0d]: got rb %b pop %b pc %h expected 1 0 2000",
                 c, roll_back, head_pop, new_pc);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({roll_back, head_pop} !== 2'b01) begin
      errors++;
      $display("FAIL stall_flush_end: got rb %b pop %b expected 0 1", roll_back, head_pop);
    end
    exp_cnt++;
    @(negedge clk);
    set_head(1'b1, 1'b1, TStore, 4'd11, 6'd0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rdy_in = 1'b0;
    store_done = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if ({store_req, store_entry, head_pop} !== {1'b1, 4'd11, 1'b0}) begin
        errors++;
        $display("FAIL stall_store[%0d]: got req %b entry %0d pop %b expected 1 11 0",
                 c, store_req, store_entry, head_pop);
      end
      @(negedge clk);
      store_done = 1'b0;
      if (c == 2) rdy_in = 1'b1;
    end
    store_done = 1'b1;
    #1;
    checks++;
    if ({store_req, head_pop} !== 2'b11) begin
      errors++;
      $display("FAIL stall_store_done: got req %b pop %b expected 1 1", store_req, head_pop);
    end
    exp_cnt++;
    @(negedge clk);
    store_done = 1'b0;
    head_valid = 1'b0;
    checks++;
    if ({store_req, commit_cnt} !== {1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL stall_cnt: got req %b cnt %0d expected 0 %0d", store_req, commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_not_ready;
    set_head(1'b1, 1'b0, TReg, 4'd1, 6'd8, 32'h9, 1'b0, 32'd0);
    #1;
    checks++;
    if (head_pop !== 1'b0) begin
      errors++;
      $display("FAIL nready_pop: got %b expected 0", head_pop);
    end
    @(negedge clk);
    head_valid = 1'b0;
    head_ready = 1'b1;
    #1;
    checks++;
    if ({head_pop, rob_commit, commit_cnt} !== {1'b0, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL nready_state: got pop %b commit %b cnt %0d expected 0 0 %0d",
               head_pop, rob_commit, commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    set_head(1'b1, 1'b1, TBranch, 4'd5, 6'd0, 32'h0, 1'b1, 32'h3000);
    @(negedge clk);
    head_valid = 1'b0;
    rst_in = 1'b0;
    #1;
    checks++;
    if ({roll_back, new_pc, commit_cnt} !== '0) begin
      errors++;
      $display("FAIL abort_flush: got rb %b pc %h cnt %0d expected 0 0 0", roll_back, new_pc, commit_cnt);
    end
    @(negedge clk);
    rst_in = 1'b1;
    set_head(1'b1, 1'b1, TReg, 4'd6, 6'd0, 32'h0, 1'b0, 32'd0);
    #1;
    checks++;
    if (head_pop !== 1'b1) begin
      errors++;
      $display("FAIL abort_run: got pop %b expected 1", head_pop);
    end
    head_valid = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.commit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.commit_cnt_q;
    set_head(1'b1, 1'b1, TReg, 4'd8, 6'd0, 32'h0, 1'b0, 32'd0);
    #1;
    checks++;
    if ({head_pop, commit_cnt} !== {1'b1, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL wrap_pre: got pop %b cnt %h expected 1 ffffffff", head_pop, commit_cnt);
    end
    @(negedge clk);
    head_valid = 1'b0;
    checks++;
    if (commit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL wrap_cnt: got %h expected 0", commit_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 32'd0;
    test_reset();
    test_back_to_back();
    test_store();
    test_mispredict();
    test_stall();
    test_not_ready();
    test_reset_abort();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
